clk_div_monitor: RTL and testbench

- Fast-domain checker for a divided clock produced elsewhere in the design, e.g. a divide-by-10 clock generator.
- Synchronises the slow clock into clk and measures each period in clk cycles.
- Declares lock after LOCK_CNT consecutive in-tolerance periods and flags period errors and loss of clock.
- Used at the consuming end of a clock divider to qualify its output before downstream logic trusts it.

---
 rtl/clk_div_monitor_if.sv | 19 +
 rtl/clk_div_monitor.sv | 132 +++++++++++++
 tb/tb_clk_div_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if: divided-clock input plus monitor status outputs.
// CLK_MON_DUTY_EN adds the duty_err output.
interface clk_div_monitor_if #(parameter int CNT_W = 8);
    logic             div_clk;
    logic             rise_pulse;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             err;
    logic             timeout;
`ifdef CLK_MON_DUTY_EN
    logic             duty_err;
    modport master (input div_clk, output rise_pulse, period, period_vld, locked, err, timeout, duty_err);
    modport slave  (output div_clk, input rise_pulse, period, period_vld, locked, err, timeout, duty_err);
`else
    modport master (input div_clk, output rise_pulse, period, period_vld, locked, err, timeout);
    modport slave  (output div_clk, input rise_pulse, period, period_vld, locked, err, timeout);
`endif
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures a divided clock's period in clk cycles and qualifies lock.
// CLK_MON_DUTY_EN adds high-time checking with a duty_err pulse.
module clk_div_monitor #(
    parameter int DIV      = 10,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int CNT_W    = 8
) (
    input logic clk,
    input logic rst,
    clk_div_monitor_if.master bus
);
    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DIV = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] C_TOL = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] C_TO  = CNT_W'(2 * DIV);
    localparam logic [3:0]       C_LCK = 4'(LOCK_CNT);
    state_t           r_state, w_state_n;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt, r_period, w_dev;
    logic [3:0]       r_mcnt, w_mcnt_n;
    logic             r_rise_pulse, r_period_vld, r_err, r_timeout;
    logic             w_rise, w_match, w_to, w_err_n, w_timeout_n, w_duty_bad;
    assign w_rise  = r_s2 & ~r_s3;
    assign w_dev   = (r_cnt > C_DIV) ? r_cnt - C_DIV : C_DIV - r_cnt;
    assign w_match = ~(&r_cnt) && (w_dev <= C_TOL);
    assign w_to    = r_cnt >= C_TO;
`ifdef CLK_MON_DUTY_EN
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV / 2);
    logic [CNT_W-1:0] r_hcnt, w_hdev;
    logic             r_duty_err, w_fall;
    assign w_fall     = ~r_s2 & r_s3;
    assign w_hdev     = (r_hcnt > C_HALF) ? r_hcnt - C_HALF : C_HALF - r_hcnt;
    assign w_duty_bad = w_fall && (r_state != IDLE) && (w_hdev > C_TOL);
    assign bus.duty_err = r_duty_err;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcnt     <= '0;
            r_duty_err <= 1'b0;
        end else begin
            r_hcnt     <= w_rise ? C_ONE : (r_s2 && !(&r_hcnt)) ? r_hcnt + C_ONE : r_hcnt;
            r_duty_err <= w_duty_bad;
        end
    end
`else
    assign w_duty_bad = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_cnt        <= '0;
            r_period     <= '0;
            r_rise_pulse <= 1'b0;
            r_period_vld <= 1'b0;
        end else begin
            r_s1         <= bus.div_clk;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_cnt        <= w_rise ? C_ONE : (r_state == IDLE || &r_cnt) ? r_cnt : r_cnt + C_ONE;
            r_rise_pulse <= w_rise;
            r_period_vld <= w_rise && (r_state != IDLE);
            r_period     <= (w_rise && r_state != IDLE) ? r_cnt : r_period;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_mcnt    <= '0;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_mcnt    <= w_mcnt_n;
            r_err     <= w_err_n;
            r_timeout <= w_timeout_n;
        end
    end
    // a rise always takes priority over a timeout landing on the same cycle
    always_comb begin
        w_state_n   = r_state;
        w_mcnt_n    = r_mcnt;
        w_err_n     = 1'b0;
        w_timeout_n = r_timeout;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_n   = TRACK;
                    w_mcnt_n    = '0;
                    w_timeout_n = 1'b0;
                end
            end
            TRACK: begin
                if (w_rise) begin
                    w_mcnt_n  = w_match ? r_mcnt + 4'd1 : '0;
                    w_state_n = (w_match && (r_mcnt + 4'd1 == C_LCK)) ? LOCKED : TRACK;
                end else if (w_to) begin
                    w_state_n   = IDLE;
                    w_mcnt_n    = '0;
                    w_timeout_n = 1'b1;
                end else if (w_duty_bad) begin
                    w_mcnt_n = '0;
                end
            end
            LOCKED: begin
                if (w_rise) begin
                    w_err_n   = ~w_match;
                    w_state_n = w_match ? LOCKED : TRACK;
                    w_mcnt_n  = w_match ? r_mcnt : '0;
                end else if (w_to) begin
                    w_err_n     = 1'b1;
                    w_state_n   = IDLE;
                    w_mcnt_n    = '0;
                    w_timeout_n = 1'b1;
                end else if (w_duty_bad) begin
                    w_err_n   = 1'b1;
                    w_state_n = TRACK;
                    w_mcnt_n  = '0;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end
    assign bus.rise_pulse = r_rise_pulse;
    assign bus.period     = r_period;
    assign bus.period_vld = r_period_vld;
    assign bus.locked     = (r_state == LOCKED);
    assign bus.err        = r_err;
    assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed div_clk patterns with a queue-based scoreboard on the main monitor.
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clk_div_monitor_if #(.CNT_W(8)) bus ();
    clk_div_monitor_if #(.CNT_W(8)) bus1 ();
    clk_div_monitor #(.DIV(10), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    clk_div_monitor #(.DIV(10), .TOL(1), .LOCK_CNT(4), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
`ifdef CLK_MON_DUTY_EN
    clk_div_monitor_if #(.CNT_W(8)) bus2 ();
    clk_div_monitor #(.DIV(10), .TOL(0), .LOCK_CNT(4), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    int duty_cnt = 0;
    always @(negedge clk) if (bus2.duty_err) duty_cnt++;
`endif

    typedef struct packed {logic v; logic [7:0] p; logic l; logic e; logic t;} ev_t;
    typedef struct {int hi; int lo; int v; int p; int l; int e; int t;} row_t;
    ev_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_rise = 0;
    logic prev_to = 1'b0;
    logic err1_seen = 1'b0;

    // hi, lo, expect period_vld, period, locked, err, then a timeout event
    row_t rows[24] = '{
        '{5,5,0,0,0,0,0},   '{5,5,1,10,0,0,0}, '{5,5,1,10,0,0,0}, '{5,5,1,10,0,0,0},
        '{5,5,1,10,1,0,0},  '{5,5,1,10,1,0,0}, '{5,7,1,10,1,0,0}, '{5,7,1,12,0,1,0},
        '{5,7,1,12,0,0,0},  '{5,7,1,12,0,0,0}, '{5,7,1,12,0,0,0}, '{5,7,1,12,0,0,0},
        '{5,5,1,12,0,0,0},  '{5,5,1,10,0,0,0}, '{5,5,1,10,0,0,0}, '{5,5,1,10,0,0,0},
        '{5,5,1,10,1,0,0},  '{5,40,1,10,1,0,1}, '{5,5,0,0,0,0,0}, '{5,5,1,10,0,0,0},
        '{5,5,1,10,0,0,0},  '{5,5,1,10,0,0,0}, '{5,5,1,10,1,0,0}, '{5,5,1,10,1,0,0}
    };

    always @(posedge clk) cyc++;
    always @(negedge clk) if (bus1.err) err1_seen = 1'b1;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_row(input row_t r);
        if (r.v != 0) q.push_back({1'b1, 8'(r.p), 1'(r.l), 1'(r.e), 1'b0});
        if (r.t != 0) q.push_back({1'b0, 8'(r.p), 1'b0, 1'b1, 1'b1});
        bus.div_clk = 1'b1;
        repeat (r.hi) @(negedge clk);
        bus.div_clk = 1'b0;
        repeat (r.lo) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rise_pulse"}, int'(bus.rise_pulse), 0);
        check({tag, "_period"}, int'(bus.period), 0);
        check({tag, "_period_vld"}, int'(bus.period_vld), 0);
        check({tag, "_locked"}, int'(bus.locked), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_timeout"}, int'(bus.timeout), 0);
    endtask

    always @(negedge clk) begin
        ev_t act, e;
        if (rst) begin
            prev_to = 1'b0;
        end else begin
            if (bus.rise_pulse) begin
                last_rise = cyc;
                if (prev_to) check("timeout_clear_on_rise", int'(bus.timeout), 0);
            end
            if (bus.period_vld || bus.err || (bus.timeout && !prev_to)) begin
                act = {bus.period_vld, bus.period, bus.locked, bus.err, bus.timeout};
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    e = q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL event vld/period/locked/err/timeout: got %0b/%0d/%0b/%0b/%0b expected %0b/%0d/%0b/%0b/%0b",
                                 act.v, act.p, act.l, act.e, act.t, e.v, e.p, e.l, e.e, e.t);
                    end
                    if (e.t) check("timeout_delay", cyc - last_rise, 20);
                end
            end
            prev_to = bus.timeout;
        end
    end

    initial begin
        bus.div_clk  = 1'b0;
        bus1.div_clk = 1'b0;
`ifdef CLK_MON_DUTY_EN
        bus2.div_clk = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        fork
            begin
                for (int i = 0; i < 24; i++) run_row(rows[i]);
                q.push_back({1'b1, 8'd10, 1'b1, 1'b0, 1'b0});
                bus.div_clk = 1'b1;
                repeat (4) @(negedge clk);
                rst = 1'b1;
                bus.div_clk = 1'b0;
                #1;
                check_reset("midrst");
                @(negedge clk);
                rst = 1'b0;
                repeat (5) @(negedge clk);
                for (int i = 0; i < 6; i++) run_row(rows[i]);
                repeat (8) @(negedge clk);
            end
            begin
                repeat (10) @(negedge clk);
                for (int k = 0; k < 5; k++) begin
                    bus1.div_clk = 1'b1;
                    repeat ((k % 2 == 1) ? 5 : 4) @(negedge clk);
                    bus1.div_clk = 1'b0;
                    repeat ((k % 2 == 1) ? 6 : 5) @(negedge clk);
                    if (k == 3) check("tol1_not_yet_locked", int'(bus1.locked), 0);
                end
                check("tol1_locked", int'(bus1.locked), 1);
                check("tol1_period", int'(bus1.period), 11);
                check("tol1_no_err", int'(err1_seen), 0);
`ifdef CLK_MON_DUTY_EN
                for (int k = 0; k < 12; k++) begin
                    bus2.div_clk = 1'b1;
                    repeat ((k < 6) ? 4 : 5) @(negedge clk);
                    bus2.div_clk = 1'b0;
                    repeat ((k < 6) ? 6 : 5) @(negedge clk);
                    if (k == 5) begin
                        check("duty_pulses", duty_cnt, 6);
                        check("duty_no_lock", int'(bus2.locked), 0);
                    end
                end
                check("duty_clean_pulses", duty_cnt, 6);
                check("duty_relock", int'(bus2.locked), 1);
`endif
            end
        join
        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
